seg_to_hex_decoder: RTL

- Receive-side counterpart of the team's hex-to-seven-segment encoder. Samples a 7-bit segment pattern bus, waits for the pattern to settle, and decodes it back to a hex nibble.
- Presents each decoded digit on a valid/ready interface.
- Packs accepted digits into a multi-digit word.
- Used to check segment-display drivers and to read captured display traffic back into numeric form.

---
 rtl/seg_to_hex_decoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_to_hex_decoder.sv
// Decodes a settled seven-segment pattern back to a hex nibble on a valid/ready
// port and packs accepted digits into a word. Define SEG_ACTIVE_LOW_EN for common-anode inputs.
module seg_to_hex_decoder #(
    parameter int STABLE_CYCLES = 3,
    parameter int DIGITS        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            segIn,
    input  logic                  hexReady,
    output logic [3:0]            hexOut,
    output logic                  hexValid,
    output logic                  errPulse,
    output logic [DIGITS*4-1:0]   wordOut,
    output logic                  wordValid
);

    localparam int WORD_W = DIGITS * 4;
    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        SETTLE,
        EMIT,
        LOCKED
    } state_t;

    state_t              state;
    logic [6:0]          segLevel;
    logic [6:0]          segQ;
    logic                change;
    logic [CNT_W-1:0]    stableCnt;
    logic                changed;
    logic [DIG_W-1:0]    digitCnt;
    logic [WORD_W-1:0]   shift;
    logic [WORD_W-1:0]   newShift;
    logic                handshake;
    logic                glyphOk;
    logic                glyphBlank;
    logic [3:0]          glyphNibble;

`ifdef SEG_ACTIVE_LOW_EN
    assign segLevel = ~segIn;
`else
    assign segLevel = segIn;
`endif

    assign change    = (segLevel != segQ);
    assign handshake = hexValid && hexReady;
    assign newShift  = (shift << 4) | WORD_W'(hexOut);

    always_ff @(posedge clk) begin
        segQ <= segLevel;
    end

    always_comb begin
        glyphOk     = 1'b1;
        glyphBlank  = 1'b0;
        glyphNibble = 4'h0;
        case (segQ)
            7'h7E: glyphNibble = 4'h0;
            7'h30: glyphNibble = 4'h1;
            7'h6D: glyphNibble = 4'h2;
            7'h79: glyphNibble = 4'h3;
            7'h33: glyphNibble = 4'h4;
            7'h5B: glyphNibble = 4'h5;
            7'h5F: glyphNibble = 4'h6;
            7'h70: glyphNibble = 4'h7;
            7'h7F: glyphNibble = 4'h8;
            7'h7B: glyphNibble = 4'h9;
            7'h77: glyphNibble = 4'hA;
            7'h1F: glyphNibble = 4'hB;
            7'h4E: glyphNibble = 4'hC;
            7'h3D: glyphNibble = 4'hD;
            7'h4F: glyphNibble = 4'hE;
            7'h47: glyphNibble = 4'hF;
            7'h00: begin
                glyphOk    = 1'b0;
                glyphBlank = 1'b1;
            end
            default: glyphOk = 1'b0;
        endcase
    end

    // Leaving EMIT for SETTLE restarts the settle window so the new pattern gets a full hold time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SETTLE;
            stableCnt <= '0;
            changed   <= 1'b0;
            digitCnt  <= '0;
            shift     <= '0;
            hexOut    <= 4'h0;
            hexValid  <= 1'b0;
            errPulse  <= 1'b0;
            wordOut   <= '0;
            wordValid <= 1'b0;
        end else begin
            errPulse  <= 1'b0;
            wordValid <= 1'b0;

            if (change)
                stableCnt <= '0;
            else if (stableCnt != CNT_MAX)
                stableCnt <= stableCnt + 1'b1;

            case (state)
                SETTLE: begin
                    if (!change && stableCnt >= CNT_FIRE) begin
                        if (glyphOk) begin
                            hexOut   <= glyphNibble;
                            hexValid <= 1'b1;
                            state    <= EMIT;
                        end else if (glyphBlank) begin
                            state <= LOCKED;
                        end else begin
                            errPulse <= 1'b1;
                            digitCnt <= '0;
                            shift    <= '0;
                            state    <= LOCKED;
                        end
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        hexValid <= 1'b0;
                        changed  <= 1'b0;
                        shift    <= newShift;
                        if (digitCnt == DIG_LAST) begin
                            wordOut   <= newShift;
                            wordValid <= 1'b1;
                            digitCnt  <= '0;
                        end else begin
                            digitCnt <= digitCnt + 1'b1;
                        end
                        if (changed || change) begin
                            state     <= SETTLE;
                            stableCnt <= '0;
                        end else begin
                            state <= LOCKED;
                        end
                    end else if (change) begin
                        changed <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (change)
                        state <= SETTLE;
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule
